// File: rtl/l15_noc1_pkt_buffer_pkg.sv
// Shared definitions for the L1.5 NoC1 store-and-forward packet buffer.
// - NoC header field placement (payload-length field) and the flit width.
// - State encodings for the input (write-side) and output (read-side) packet FSMs.
package l15_noc1_pkt_buffer_pkg;

  localparam int NOC_DATA_W  = 64;
  localparam int NOC_LEN_LSB = 22;
  localparam int NOC_LEN_W   = 8;

  // Write side: IN_HDR expects a header flit, IN_BODY is collecting payload flits.
  typedef enum logic {
    IN_HDR  = 1'b0,
    IN_BODY = 1'b1
  } in_state_e;

  // Read side: OUT_HDR is about to send a header, OUT_BODY is mid-packet.
  typedef enum logic {
    OUT_HDR  = 1'b0,
    OUT_BODY = 1'b1
  } out_state_e;

endpackage

// File: rtl/l15_noc1_pkt_buffer_fifo.sv
// Generic DEPTH x DATA_W synchronous flit FIFO.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push_i/push_data_i  write request and flit (ignored while full)
//   pop_i            read request (ignored while empty)
//   rd_data_o        head flit, read straight from the storage flops, so it is
//                    valid one cycle after the write and stable until popped
//   empty_o/full_o   status from the registered count
//   count_o          number of stored flits (0..DEPTH)
module noc_flit_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap modulo DEPTH by natural overflow; the count tells full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: its contents are only observed through count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/l15_noc1_pkt_buffer.sv
// Store-and-forward packet buffer between the L1.5 NoC1 request output and the
// NoC1 router input port. A packet is released to the router only once all of
// its flits are stored, so the router is never held mid-packet by L1.5 stalls.
// Packets longer than the buffer are cut through instead, and flagged.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_val/in_data    flit from L1.5; in_rdy back to L1.5 (registers only)
//   out_val/out_data  flit to router; out_rdy from router
//   occupancy         flits stored
//   pkt_count         complete packets stored
//   err_oversize      sticky: a packet longer than DEPTH flits was seen
// Handshake: a flit moves on any rising clk where valid && ready on that side;
// valid never depends on ready, and a presented flit stays put until taken.
module l15_noc1_pkt_buffer
  import l15_noc1_pkt_buffer_pkg::*;
#(
  parameter int DATA_W  = NOC_DATA_W,
  parameter int DEPTH   = 16,
  parameter int LEN_LSB = NOC_LEN_LSB,
  parameter int LEN_W   = NOC_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_val,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_rdy,
  output logic                    out_val,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_rdy,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [$clog2(DEPTH):0]  pkt_count,
  output logic                    err_oversize
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             fifo_empty, fifo_full;
  logic             wr, rd;
  logic [LEN_W-1:0] in_len, out_len;
  logic             in_oversize;

  in_state_e        in_state_q, in_state_d;
  out_state_e       out_state_q, out_state_d;
  logic [LEN_W-1:0] in_rem_q, in_rem_d;
  logic [LEN_W-1:0] out_rem_q, out_rem_d;
  logic             in_done, out_done, ct_set;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic             ct_mode_q, ct_mode_d;
  logic             err_q, err_d;
  logic             rdy_en_q;

  // rdy_en_q holds in_rdy low through reset and the first edge after it.
  assign in_rdy = rdy_en_q && !fifo_full;
  assign wr     = in_val && in_rdy;

  // Release when a whole packet is stored, when the head packet is already
  // partly sent, or when an oversize packet is streaming through.
  assign out_val = !fifo_empty &&
                   ((pkt_count_q != '0) || (out_state_q == OUT_BODY) || ct_mode_q);
  assign rd      = out_val && out_rdy;

  assign in_len      = in_data[LEN_LSB +: LEN_W];
  assign out_len     = out_data[LEN_LSB +: LEN_W];
  // len + 1 > DEPTH, written as len >= DEPTH to avoid the carry.
  assign in_oversize = (32'(in_len) >= 32'(DEPTH));

  assign pkt_count    = pkt_count_q;
  assign err_oversize = err_q;

  noc_flit_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wr),
    .push_data_i (in_data),
    .pop_i       (rd),
    .rd_data_o   (out_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (occupancy)
  );

  // Input FSM: tracks packet boundaries on the write side.
  always_comb begin
    in_state_d = in_state_q;
    in_rem_d   = in_rem_q;
    in_done    = 1'b0;
    ct_set     = 1'b0;
    if (wr) begin
      unique case (in_state_q)
        IN_HDR: begin
          if (in_len == '0) begin
            in_done = 1'b1;
          end else begin
            in_rem_d   = in_len;
            in_state_d = IN_BODY;
            ct_set     = in_oversize;
          end
        end
        IN_BODY: begin
          in_rem_d = in_rem_q - LEN_W'(1);
          if (in_rem_q == LEN_W'(1)) begin
            in_done    = 1'b1;
            in_state_d = IN_HDR;
          end
        end
        default: in_state_d = IN_HDR;
      endcase
    end
  end

  // Output FSM: tracks packet boundaries on the read side.
  always_comb begin
    out_state_d = out_state_q;
    out_rem_d   = out_rem_q;
    out_done    = 1'b0;
    if (rd) begin
      unique case (out_state_q)
        OUT_HDR: begin
          if (out_len == '0) begin
            out_done = 1'b1;
          end else begin
            out_rem_d   = out_len;
            out_state_d = OUT_BODY;
          end
        end
        OUT_BODY: begin
          out_rem_d = out_rem_q - LEN_W'(1);
          if (out_rem_q == LEN_W'(1)) begin
            out_done    = 1'b1;
            out_state_d = OUT_HDR;
          end
        end
        default: out_state_d = OUT_HDR;
      endcase
    end
  end

  // Packet count, cut-through mode and the sticky oversize flag.
  always_comb begin
    pkt_count_d = pkt_count_q;
    unique case ({in_done, out_done})
      2'b10:   pkt_count_d = pkt_count_q + CNT_W'(1);
      2'b01:   pkt_count_d = pkt_count_q - CNT_W'(1);
      default: pkt_count_d = pkt_count_q;
    endcase

    ct_mode_d = ct_mode_q;
    if (ct_set)       ct_mode_d = 1'b1;
    else if (in_done) ct_mode_d = 1'b0;

    err_d = err_q || ct_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state_q  <= IN_HDR;
      out_state_q <= OUT_HDR;
      in_rem_q    <= '0;
      out_rem_q   <= '0;
      pkt_count_q <= '0;
      ct_mode_q   <= 1'b0;
      err_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      in_rem_q    <= in_rem_d;
      out_rem_q   <= out_rem_d;
      pkt_count_q <= pkt_count_d;
      ct_mode_q   <= ct_mode_d;
      err_q       <= err_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l15_noc1_pkt_buffer.sv
// Self-checking bench for l15_noc1_pkt_buffer.
// The reference model keeps the stored flits in a queue, each tagged by the
// driver with header/last/oversize, and derives every output from that queue.
module tb_l15_noc1_pkt_buffer;

  localparam int DATA_W  = 64;
  localparam int DEPTH   = 16;
  localparam int LEN_LSB = 22;
  localparam int LEN_W   = 8;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_val = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_rdy;
  logic              out_val;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy = 1'b0;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W-1:0]  pkt_count;
  logic              err_oversize;

  // Driver-side tags travelling with in_data (not DUT ports).
  bit tag_hdr = 1'b0;
  bit tag_last = 1'b0;
  bit tag_ovs = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  l15_noc1_pkt_buffer #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LEN_LSB (LEN_LSB),
    .LEN_W   (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_val       (in_val),
    .in_data      (in_data),
    .in_rdy       (in_rdy),
    .out_val      (out_val),
    .out_data     (out_data),
    .out_rdy      (out_rdy),
    .occupancy    (occupancy),
    .pkt_count    (pkt_count),
    .err_oversize (err_oversize)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  bit                hdr_q[$];
  bit                last_q[$];
  bit                ovs_q[$];

  bit                m_rdy_en  = 1'b0;
  bit                e_in_rdy  = 1'b0;
  bit                e_out_val = 1'b0;
  bit                e_err     = 1'b0;
  int                e_occ     = 0;
  int                e_pkt     = 0;
  logic [DATA_W-1:0] e_data    = '0;

  function automatic void model_outputs();
    int nl = 0;
    foreach (last_q[i]) if (last_q[i]) nl++;
    e_occ    = exp_q.size();
    e_pkt    = nl;
    e_in_rdy = m_rdy_en && (e_occ != DEPTH);
    // The head packet may go if some whole packet is stored (the oldest one is
    // then whole), if it is already partly sent, or if it is an oversize one.
    e_out_val = (e_occ != 0) && ((nl != 0) || !hdr_q[0] || ovs_q[0]);
    e_data    = (e_occ != 0) ? exp_q[0] : '0;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit wr;
    bit rd;
    if (rst) begin
      exp_q.delete();
      hdr_q.delete();
      last_q.delete();
      ovs_q.delete();
      m_rdy_en = 1'b0;
      e_err    = 1'b0;
    end else begin
      wr = in_val && e_in_rdy;
      rd = e_out_val && out_rdy;
      if (rd) begin
        void'(exp_q.pop_front());
        void'(hdr_q.pop_front());
        void'(last_q.pop_front());
        void'(ovs_q.pop_front());
      end
      if (wr) begin
        exp_q.push_back(in_data);
        hdr_q.push_back(tag_hdr);
        last_q.push_back(tag_last);
        ovs_q.push_back(tag_ovs);
        if (tag_hdr && tag_ovs) e_err = 1'b1;
      end
      m_rdy_en = 1'b1;
    end
    model_outputs();
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("in_rdy", 64'(in_rdy), 64'(e_in_rdy));
    check("out_val", 64'(out_val), 64'(e_out_val));
    check("occupancy", 64'(occupancy), 64'(e_occ));
    check("pkt_count", 64'(pkt_count), 64'(e_pkt));
    check("err_oversize", 64'(err_oversize), 64'(e_err));
    if (e_out_val && out_val) check("out_data", out_data, e_data);
  end

  // ---------------- driver tasks (called and returning at a falling edge) ----------------
  function automatic logic [63:0] mk_hdr(input int len);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[LEN_LSB +: LEN_W] = LEN_W'(len);
    return d;
  endfunction

  function automatic logic [63:0] mk_body();
    return {$urandom, $urandom};
  endfunction

  task automatic send_flit(input logic [63:0] d, input bit h, input bit l, input bit o);
    int waited = 0;
    in_val   = 1'b1;
    in_data  = d;
    tag_hdr  = h;
    tag_last = l;
    tag_ovs  = o;
    while (!e_in_rdy) begin
      @(negedge clk);
      waited++;
      if (waited > 300) begin
        timeout_fail("send_flit");
        in_val = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_val   = 1'b0;
    tag_hdr  = 1'b0;
    tag_last = 1'b0;
    tag_ovs  = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int gap);
    for (int i = 0; i <= len; i++) begin
      send_flit((i == 0) ? mk_hdr(len) : mk_body(), i == 0, i == len, len >= DEPTH);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (e_occ != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (e_occ != 0) timeout_fail(name);
    else check(name, 64'(occupancy), 64'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lens[6] = '{2, 0, 5, 1, 15, 3};

    repeat (2) @(negedge clk);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_out_val", 64'(out_val), 64'd0);
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    check("rst_err", 64'(err_oversize), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_rdy", 64'(in_rdy), 64'd1);

    // 1: single header, len 0
    out_rdy = 1'b1;
    send_flit(mk_hdr(0), 1'b1, 1'b1, 1'b0);
    check("t1_out_val", 64'(out_val), 64'd1);
    check("t1_pkt_count1", 64'(pkt_count), 64'd1);
    check("t1_occ1", 64'(occupancy), 64'd1);
    @(negedge clk);
    check("t1_pkt_count0", 64'(pkt_count), 64'd0);
    check("t1_occ0", 64'(occupancy), 64'd0);

    // 2: len 3, flits two cycles apart; held until whole, then back-to-back
    send_flit(mk_hdr(3), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    send_flit(mk_body(), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    send_flit(mk_body(), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_held_out_val", 64'(out_val), 64'd0);
    check("t2_held_occ", 64'(occupancy), 64'd3);
    send_flit(mk_body(), 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("t2_stream", 64'(out_val), 64'd1);
      @(negedge clk);
    end
    check("t2_done_out_val", 64'(out_val), 64'd0);
    check("t2_done_occ", 64'(occupancy), 64'd0);

    // 3: fill with 16 single-flit packets, then drain
    out_rdy = 1'b0;
    for (int k = 0; k < DEPTH; k++) send_flit(mk_hdr(0), 1'b1, 1'b1, 1'b0);
    check("t3_full_in_rdy", 64'(in_rdy), 64'd0);
    check("t3_full_occ", 64'(occupancy), 64'd16);
    check("t3_full_pkts", 64'(pkt_count), 64'd16);
    out_rdy = 1'b1;
    @(negedge clk);
    check("t3_rdy_back", 64'(in_rdy), 64'd1);
    check("t3_occ15", 64'(occupancy), 64'd15);
    wait_drain("t3_drain");

    // 4: end-of-packet write together with a read ending another packet
    out_rdy = 1'b0;
    send_flit(mk_hdr(0), 1'b1, 1'b1, 1'b0);
    send_flit(mk_hdr(1), 1'b1, 1'b0, 1'b0);
    check("t4_pre_pkts", 64'(pkt_count), 64'd1);
    check("t4_pre_occ", 64'(occupancy), 64'd2);
    in_val   = 1'b1;
    in_data  = mk_body();
    tag_last = 1'b1;
    out_rdy  = 1'b1;
    @(negedge clk);
    in_val   = 1'b0;
    tag_last = 1'b0;
    check("t4_post_pkts", 64'(pkt_count), 64'd1);
    check("t4_post_occ", 64'(occupancy), 64'd2);
    wait_drain("t4_drain");

    // 5: oversize packet, len 20, cut through
    send_flit(mk_hdr(20), 1'b1, 1'b0, 1'b1);
    check("t5_err", 64'(err_oversize), 64'd1);
    check("t5_ct_out_val", 64'(out_val), 64'd1);
    for (int k = 1; k <= 20; k++) send_flit(mk_body(), 1'b0, k == 20, 1'b1);
    wait_drain("t5_drain");
    check("t5_err_sticky", 64'(err_oversize), 64'd1);

    // 7: mixed lengths under random router backpressure
    fork
      begin
        foreach (lens[k]) send_pkt(lens[k], $urandom_range(0, 1));
      end
      begin
        repeat (150) begin
          @(negedge clk);
          out_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    out_rdy = 1'b1;
    wait_drain("t7_drain");

    // 6: reset with one packet half read and the next half written
    out_rdy = 1'b0;
    send_pkt(5, 0);
    send_flit(mk_hdr(5), 1'b1, 1'b0, 1'b0);
    send_flit(mk_body(), 1'b0, 1'b0, 1'b0);
    send_flit(mk_body(), 1'b0, 1'b0, 1'b0);
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    out_rdy = 1'b0;
    check("t6_pre_occ", 64'(occupancy), 64'd6);
    #2 rst = 1'b1;
    @(negedge clk);
    check("t6_rst_occ", 64'(occupancy), 64'd0);
    check("t6_rst_pkts", 64'(pkt_count), 64'd0);
    check("t6_rst_out_val", 64'(out_val), 64'd0);
    check("t6_rst_err", 64'(err_oversize), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    out_rdy = 1'b1;
    send_flit(mk_hdr(0), 1'b1, 1'b1, 1'b0);
    check("t6_fresh_pkts", 64'(pkt_count), 64'd1);
    check("t6_fresh_out_val", 64'(out_val), 64'd1);
    wait_drain("t6_drain");

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
